// File: rtl/uart_loader.sv
// uart_loader: receives a framed program over UART and writes it into instruction memory.
// Parameter:
//    TIMEOUT    inter-byte timeout in clk cycles while a load frame is in progress
// Ports:
//    clk        system clock, rising edge
//    reset      synchronous active-low reset
//    rx_update  one-cycle strobe, rx_data holds a new received byte
//    rx_data    received byte
//    wr_en      one-cycle instruction-memory write strobe
//    wr_addr    word address of the write
//    wr_data    word to write
//    tx_req     one-cycle send request for the response byte
//    tx_data    response byte (0x06 ACK, 0x15 NAK), valid with tx_req
//    tx_busy    transmitter busy, tx_req is held off while high
//    loading    high while a load frame is in progress
//    cpu_run    high after a successful load, releases the CPU
module uart_loader #(
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_update,
   input  logic [7:0]  rx_data,
   output logic        wr_en,
   output logic [10:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        tx_req,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        loading,
   output logic        cpu_run
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM} state_t;
   state_t state, state_n;
   logic [15:0]   len;
   logic [11:0]   widx;
   logic [1:0]    bcnt;
   logic [23:0]   asm_r;
   logic [7:0]    csum;
   logic [TW-1:0] timer;
   logic          pending;
   logic [7:0]    resp;
   logic          start, resp_v, timeout;
   logic [7:0]    resp_b;
   logic [15:0]   n_len;
   assign n_len   = {rx_data, len[7:0]};
   assign timeout = (state != IDLE) && !rx_update && (timer == TW'(TIMEOUT - 1));
   assign loading = (state != IDLE);
   // Response goes out on the first cycle the transmitter is free.
   assign tx_req  = pending && !tx_busy;
   assign tx_data = resp;
   always_comb begin
      state_n = state;
      start   = 1'b0;
      resp_v  = 1'b0;
      resp_b  = 8'h15;
      if (timeout) begin
         state_n = IDLE;
         resp_v  = 1'b1;
      end else if (rx_update) begin
         case (state)
            IDLE: begin
               start   = (rx_data == 8'hA5);
               state_n = start ? LEN_LO : IDLE;
            end
            LEN_LO: state_n = LEN_HI;
            LEN_HI: begin
               resp_v  = (n_len == 16'd0) || (n_len > 16'd2048);
               state_n = resp_v ? IDLE : DATA;
            end
            DATA: state_n = (bcnt == 2'd3 && {4'd0, widx} == len - 16'd1) ? CSUM : DATA;
            CSUM: begin
               state_n = IDLE;
               resp_v  = 1'b1;
               resp_b  = (rx_data == csum) ? 8'h06 : 8'h15;
            end
            default: state_n = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         len     <= '0;
         widx    <= '0;
         bcnt    <= '0;
         asm_r   <= '0;
         csum    <= '0;
         timer   <= '0;
         pending <= 1'b0;
         resp    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         cpu_run <= 1'b0;
      end else begin
         state <= state_n;
         wr_en <= 1'b0;
         timer <= (rx_update || state == IDLE) ? '0 : timer + 1'b1;
         if (start) begin
            cpu_run <= 1'b0;
            bcnt    <= '0;
            widx    <= '0;
            wr_addr <= '0;
            csum    <= '0;
         end
         if (rx_update && state == LEN_LO) len[7:0] <= rx_data;
         if (rx_update && state == LEN_HI) len[15:8] <= rx_data;
         if (rx_update && state == DATA) begin
            // Little-endian words: bytes shift in from the top, first byte ends in bits 7:0.
            asm_r <= {rx_data, asm_r[23:8]};
            csum  <= csum + rx_data;
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               wr_en   <= 1'b1;
               wr_data <= {rx_data, asm_r};
               wr_addr <= widx[10:0];
               widx    <= widx + 12'd1;
            end
         end
         if (rx_update && state == CSUM) cpu_run <= (rx_data == csum);
         // A fresh response overwrites one still waiting, so only the latest is sent.
         if (resp_v) begin
            pending <= 1'b1;
            resp    <= resp_b;
         end else if (tx_req) begin
            pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed self-checking bench for uart_loader.
module tb_uart_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_update = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [31:0] wr_data;
   logic        tx_req;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        loading;
   logic        cpu_run;
   int npass = 0;
   int ntot = 0;
   int nw = 0;
   int ntx = 0;
   logic [7:0] last_tx = 8'h00;
   int busy_req = 0;
   uart_loader #(.TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .rx_update(rx_update), .rx_data(rx_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .tx_req(tx_req), .tx_data(tx_data), .tx_busy(tx_busy),
      .loading(loading), .cpu_run(cpu_run)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (wr_en) nw <= nw + 1;
      if (tx_req) begin
         ntx     <= ntx + 1;
         last_tx <= tx_data;
      end
      if (tx_req && tx_busy) busy_req <= busy_req + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_update = 1'b1;
      rx_data   = b;
      @(negedge clk);
      rx_update = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      int w0, t0;
      idle(3);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_tx_req", 32'(tx_req), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_loading", 32'(loading), 32'd0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      reset = 1'b1;
      idle(2);
      send(8'h00); send(8'hFF); send(8'h12);
      chk("garbage_loading", 32'(loading), 32'd0);
      send(8'hA5);
      chk("a5_loading", 32'(loading), 32'd1);
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      chk("w0_en", 32'(wr_en), 32'd1);
      chk("w0_addr", 32'(wr_addr), 32'd0);
      chk("w0_data", wr_data, 32'h0000_0013);
      idle(1);
      chk("w0_en_one_cycle", 32'(wr_en), 32'd0);
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      chk("w1_en", 32'(wr_en), 32'd1);
      chk("w1_addr", 32'(wr_addr), 32'd1);
      chk("w1_data", wr_data, 32'h0010_0093);
      chk("csum_loading", 32'(loading), 32'd1);
      send(8'hB6);
      idle(3);
      chk("ack_count", 32'(ntx), 32'd1);
      chk("ack_byte", 32'(last_tx), 32'h06);
      chk("ack_cpu_run", 32'(cpu_run), 32'd1);
      chk("ack_loading", 32'(loading), 32'd0);
      chk("ack_writes", 32'(nw), 32'd2);
      send(8'hA5);
      chk("restart_cpu_run", 32'(cpu_run), 32'd0);
      chk("restart_loading", 32'(loading), 32'd1);
      send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      send(8'h00);
      idle(3);
      chk("bad_csum_writes", 32'(nw), 32'd4);
      chk("bad_csum_count", 32'(ntx), 32'd2);
      chk("bad_csum_byte", 32'(last_tx), 32'h15);
      chk("bad_csum_cpu_run", 32'(cpu_run), 32'd0);
      send(8'hA5); send(8'h00); send(8'h00);
      idle(3);
      chk("n0_writes", 32'(nw), 32'd4);
      chk("n0_count", 32'(ntx), 32'd3);
      chk("n0_byte", 32'(last_tx), 32'h15);
      chk("n0_loading", 32'(loading), 32'd0);
      send(8'hA5); send(8'h01); send(8'h08);
      idle(3);
      chk("n2049_count", 32'(ntx), 32'd4);
      chk("n2049_byte", 32'(last_tx), 32'h15);
      chk("n2049_loading", 32'(loading), 32'd0);
      send(8'hA5); send(8'h01); send(8'h00); send(8'hAA);
      idle(90);
      chk("to_early_loading", 32'(loading), 32'd1);
      chk("to_early_count", 32'(ntx), 32'd4);
      t0 = 0;
      while (ntx == 4 && t0 < 40) begin
         idle(1);
         t0++;
      end
      chk("to_count", 32'(ntx), 32'd5);
      chk("to_byte", 32'(last_tx), 32'h15);
      chk("to_loading", 32'(loading), 32'd0);
      chk("to_cpu_run", 32'(cpu_run), 32'd0);
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("busy_w_data", wr_data, 32'h4433_2211);
      tx_busy = 1'b1;
      send(8'hAA);
      idle(48);
      chk("busy_held_count", 32'(ntx), 32'd5);
      chk("busy_held_req", 32'(tx_req), 32'd0);
      chk("busy_cpu_run", 32'(cpu_run), 32'd1);
      tx_busy = 1'b0;
      #1;
      chk("busy_release_req", 32'(tx_req), 32'd1);
      chk("busy_release_data", 32'(tx_data), 32'h06);
      idle(1);
      chk("busy_pulse_one", 32'(tx_req), 32'd0);
      idle(3);
      chk("busy_count", 32'(ntx), 32'd6);
      chk("busy_never_req", 32'(busy_req), 32'd0);
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05); send(8'h06);
      w0 = nw;
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(20);
      chk("rstmid_writes", 32'(nw), 32'(w0));
      chk("rstmid_count", 32'(ntx), 32'd6);
      chk("rstmid_cpu_run", 32'(cpu_run), 32'd0);
      chk("rstmid_loading", 32'(loading), 32'd0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter: TIMEOUT, 1000000, inter-byte timeout in clk cycles during a load.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous active-low reset.
REQ-004 Port: rx_update  input  1  one-cycle pulse; rx_data holds a newly received UART byte.
REQ-005 Port: rx_data  input  8  received byte, valid when rx_update=1.
REQ-006 Port: wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-007 Port: wr_addr  output  11  word address of the write.
REQ-008 Port: wr_data  output  32  word to write.
REQ-009 Port: tx_req  output  1  one-cycle send request to the UART transmitter.
REQ-010 Port: tx_data  output  8  response byte, valid while tx_req=1.
REQ-011 Port: tx_busy  input  1  transmitter busy; tx_req is never asserted while high.
REQ-012 Port: loading  output  1  high while a load frame is in progress.
REQ-013 Port: cpu_run  output  1  high after a successful load; CPU is held in reset while low.

Function
REQ-014 Frame format: magic 0xA5, LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N payload bytes (words little-endian, first byte = bits 7:0), one checksum byte.
REQ-015 FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM; transitions occur only on cycles with rx_update=1 or on timeout.
REQ-016 IDLE: 0xA5 -> LEN_LO, clears cpu_run, byte counter, word address and checksum; any other byte is ignored.
REQ-017 LEN_LO -> LEN_HI -> DATA; if N=0 or N>2048 after LEN_HI -> IDLE with NAK.
REQ-018 DATA: bytes shift into a 32-bit assembly register; the 4th byte of each word produces wr_en=1 for exactly one cycle, one cycle after that rx_update, with wr_data = assembled word and wr_addr = word index (0 for first word).
REQ-019 wr_addr increments after each write; after word N-1 the FSM enters CSUM; wr_addr never wraps (N<=2048).
REQ-020 Checksum = 8-bit modulo-256 sum of all 4*N payload bytes (header and magic excluded).
REQ-021 CSUM: received byte equal to computed checksum -> IDLE, cpu_run=1, ACK 0x06; otherwise -> IDLE, cpu_run=0, NAK 0x15.
REQ-022 Words already written before a NAK remain in memory; cpu_run stays 0.
REQ-023 Timeout: a cycle counter clears on every rx_update; in any state other than IDLE, TIMEOUT cycles without rx_update -> IDLE with NAK.
REQ-024 loading=1 exactly in states LEN_LO, LEN_HI, DATA, CSUM.
REQ-025 Response path: a pending flag and byte are set on ACK/NAK; tx_req pulses one cycle on the first cycle pending=1 and tx_busy=0, then pending clears.
REQ-026 A new response while one is still pending overwrites the pending byte; only one response is sent.
REQ-027 Bytes arriving while a response is pending are processed normally by the FSM.
REQ-028 A new 0xA5 in IDLE after a successful load restarts loading and drops cpu_run in the same cycle the state changes.

Reset
REQ-029 With reset=0 at a clock edge: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, tx_req=0, tx_data=0, loading=0, cpu_run=0, pending, counters and checksum cleared.
REQ-030 Reset mid-frame aborts the load with no further writes and no response byte.

Verification
REQ-031 Frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | B6 -> writes addr0=0x00000013, addr1=0x00100093, each wr_en one cycle after the 4th byte; tx_req with 0x06; cpu_run=1.
REQ-032 Same frame with checksum 0x00 -> both writes occur, tx_data=0x15, cpu_run=0.
REQ-033 A5 00 00 -> no wr_en, NAK 0x15; A5 01 08 (N=2049) -> NAK 0x15.
REQ-034 TIMEOUT=100; A5 01 00 AA then silence -> after 100 idle cycles NAK 0x15, loading=0.
REQ-035 tx_busy held high 50 cycles when ACK is due -> tx_req=0 throughout, single tx_req pulse in first cycle tx_busy=0.
REQ-036 Garbage 00 FF 12 before a valid frame -> ignored, frame loads correctly; reset=0 during DATA -> no further wr_en, no tx_req, cpu_run=0.
